// File: rtl/placar_display_c2.sv
// Sign/BCD conversion of the adder's 6-bit two's-complement result by repeated
// subtraction, driving a 3-digit multiplexed 7-segment display (sign, tens, units).
module placar_display_c2 #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] s,
    input  logic       load,
    output logic       busy,
    output logic       valid,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int            PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [2:0]    AN_OFF    = SEG_ACTIVE_LOW ? 3'b111 : 3'b000;
    localparam logic [6:0]    PAT_MINUS = 7'h40;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t         state_r, next_state_s;
    logic           sign_w_r, sign_next_s;
    logic [5:0]     mag_r, mag_next_s;
    logic [1:0]     tens_w_r, tens_next_s;
    logic           commit_s;
    logic           disp_sign_r;
    logic [1:0]     disp_tens_r;
    logic [3:0]     disp_units_r;
    logic [PW-1:0]  presc_r;
    logic [1:0]     digit_r;
    logic [2:0]     an_on_s;
    logic [6:0]     pat_s;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    // Next-state and conversion datapath: capture on load, subtract ten per cycle.
    always_comb begin
        next_state_s = state_r;
        sign_next_s  = sign_w_r;
        mag_next_s   = mag_r;
        tens_next_s  = tens_w_r;
        commit_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load) begin
                    next_state_s = ST_CONV;
                    sign_next_s  = s[5];
                    mag_next_s   = s[5] ? (~s + 6'd1) : s;
                    tens_next_s  = 2'd0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (mag_r >= 6'd10) begin
                    mag_next_s  = mag_r - 6'd10;
                    tens_next_s = tens_w_r + 2'd1;
                end else begin
                    commit_s     = 1'b1;
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, working registers, and the atomically committed display value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sign_w_r     <= 1'b0;
            mag_r        <= 6'd0;
            tens_w_r     <= 2'd0;
            disp_sign_r  <= 1'b0;
            disp_tens_r  <= 2'd0;
            disp_units_r <= 4'd0;
            busy         <= 1'b0;
            valid        <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            sign_w_r <= sign_next_s;
            mag_r    <= mag_next_s;
            tens_w_r <= tens_next_s;
            busy     <= (next_state_s == ST_CONV);
            if (commit_s) begin
                disp_sign_r  <= sign_w_r;
                disp_tens_r  <= tens_w_r;
                disp_units_r <= mag_r[3:0];
                valid        <= 1'b1;
            end else begin
                valid <= valid;
            end
        end
    end

    // Free-running scan prescaler and digit index, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
            digit_r <= 2'd0;
        end else if (presc_r == PRESC_MAX) begin
            presc_r <= '0;
            digit_r <= (digit_r == 2'd2) ? 2'd0 : (digit_r + 2'd1);
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Active-high digit enable and segment pattern for the digit being scanned.
    always_comb begin
        an_on_s = 3'b000;
        pat_s   = 7'h00;
        if (valid) begin
            case (digit_r)
                2'd0: begin
                    an_on_s = 3'b001;
                    pat_s   = seg_enc(disp_units_r);
                end
                2'd1: begin
                    an_on_s = 3'b010;
                    if (disp_tens_r != 2'd0) begin
                        pat_s = seg_enc({2'b00, disp_tens_r});
                    end else begin
                        pat_s = 7'h00;
                    end
                end
                2'd2: begin
                    an_on_s = 3'b100;
                    if (disp_sign_r) begin
                        pat_s = PAT_MINUS;
                    end else begin
                        pat_s = 7'h00;
                    end
                end
                default: begin
                    an_on_s = 3'b000;
                    pat_s   = 7'h00;
                end
            endcase
        end else begin
            an_on_s = 3'b000;
            pat_s   = 7'h00;
        end
    end

    // Registered display drive; an and seg move together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= SEG_ACTIVE_LOW ? ~an_on_s : an_on_s;
            seg <= SEG_ACTIVE_LOW ? ~pat_s : pat_s;
        end
    end

endmodule

// File: tb/tb_placar_display_c2.sv
// Self-checking bench for placar_display_c2 (SCAN_DIV=4, active-low board),
// using an arithmetic reference model of the sign/tens/units decomposition.
module tb_placar_display_c2;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [5:0] s;
    logic       load;
    logic       busy;
    logic       valid;
    logic [6:0] seg;
    logic [2:0] an;

    int n_checks = 0;
    int n_fail   = 0;
    logic [6:0] enc_tab [0:9];

    placar_display_c2 #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .s(s), .load(load),
        .busy(busy), .valid(valid), .seg(seg), .an(an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: expected active-low segments and conversion cycles from arithmetic.
    task automatic exp_segs(input logic [5:0] v, output logic [6:0] eu, output logic [6:0] et,
                            output logic [6:0] es, output int cyc);
        int val, mag, tens, units;
        val   = v[5] ? (int'(v) - 64) : int'(v);
        mag   = (val < 0) ? -val : val;
        tens  = mag / 10;
        units = mag % 10;
        eu    = 7'h7F ^ enc_tab[units];
        et    = (tens != 0) ? (7'h7F ^ enc_tab[tens]) : 7'h7F;
        es    = (val < 0) ? (7'h7F ^ 7'h40) : 7'h7F;
        cyc   = tens + 1;
    endtask

    task automatic run_conv(input logic [5:0] v, input int inject_at, input logic [5:0] inject_v,
                            output int bc, output bit timed_out);
        int guard;
        s = v;
        load = 1'b1;
        tick();
        load = 1'b0;
        s = 6'($urandom);
        bc = 0;
        guard = 0;
        timed_out = 1'b0;
        while (busy === 1'b1 && guard < 100) begin
            bc++;
            if (bc == inject_at) begin
                load = 1'b1;
                s = inject_v;
            end
            tick();
            load = 1'b0;
            guard++;
        end
        if (guard >= 100) timed_out = 1'b1;
    endtask

    task automatic capture_scan(output logic [6:0] useg, output logic [6:0] tseg,
                                output logic [6:0] sseg, output logic [2:0] seen,
                                output int bad, output int incons);
        useg = 7'h00; tseg = 7'h00; sseg = 7'h00;
        seen = 3'b000; bad = 0; incons = 0;
        for (int i = 0; i < 3 * SCAN_DIV + 2; i++) begin
            tick();
            case (an)
                3'b110: begin if (seen[0] && useg !== seg) incons++; useg = seg; seen[0] = 1'b1; end
                3'b101: begin if (seen[1] && tseg !== seg) incons++; tseg = seg; seen[1] = 1'b1; end
                3'b011: begin if (seen[2] && sseg !== seg) incons++; sseg = seg; seen[2] = 1'b1; end
                default: bad++;
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || valid !== 1'b0 || an !== 3'b111 || seg !== 7'h7F) begin
                n_fail++;
                $display("FAIL reset_hold: busy=%b valid=%b an=%b seg=%h, required 0 0 111 7f", busy, valid, an, seg);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || valid !== 1'b0 || an !== 3'b111 || seg !== 7'h7F) begin
                n_fail++;
                $display("FAIL reset_release: busy=%b valid=%b an=%b seg=%h, required 0 0 111 7f", busy, valid, an, seg);
            end
        end
    endtask

    task automatic test_conversion(input string name, input logic [5:0] v,
                                   input int inject_at, input logic [5:0] inject_v);
        logic [6:0] eu, et, es, useg, tseg, sseg;
        logic [2:0] seen;
        int cyc, bc, bad, incons;
        bit to;
        exp_segs(v, eu, et, es, cyc);
        run_conv(v, inject_at, inject_v, bc, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL %s timeout: busy never deasserted", name); end
        n_checks++;
        if (bc != cyc) begin n_fail++; $display("FAIL %s busy_cycles: got %0d, required %0d (s=%b)", name, bc, cyc, v); end
        n_checks++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL %s valid: got %b, required 1", name, valid); end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_restart: got %b, required 0", name, busy); end
        capture_scan(useg, tseg, sseg, seen, bad, incons);
        n_checks++;
        if (seen !== 3'b111 || bad != 0 || incons != 0) begin
            n_fail++;
            $display("FAIL %s scan: seen=%b bad_an=%0d unstable=%0d, required 111 0 0", name, seen, bad, incons);
        end
        n_checks++;
        if (useg !== eu) begin n_fail++; $display("FAIL %s units: got %h, required %h (s=%b)", name, useg, eu, v); end
        n_checks++;
        if (tseg !== et) begin n_fail++; $display("FAIL %s tens: got %h, required %h (s=%b)", name, tseg, et, v); end
        n_checks++;
        if (sseg !== es) begin n_fail++; $display("FAIL %s sign: got %h, required %h (s=%b)", name, sseg, es, v); end
    endtask

    task automatic test_scan_order();
        logic [2:0] hist [$];
        logic [2:0] nxt;
        int run, nrun;
        for (int i = 0; i < 13 * SCAN_DIV; i++) begin
            tick();
            hist.push_back(an);
        end
        run = 1;
        nrun = 0;
        for (int i = 1; i < hist.size(); i++) begin
            if (hist[i] == hist[i-1]) begin
                run++;
            end else begin
                if (nrun > 0) begin
                    n_checks++;
                    if (run != SCAN_DIV) begin n_fail++; $display("FAIL scan_hold: an=%b held %0d, required %0d", hist[i-1], run, SCAN_DIV); end
                end
                nxt = {hist[i-1][1:0], hist[i-1][2]};
                n_checks++;
                if (hist[i] !== nxt) begin n_fail++; $display("FAIL scan_order: an %b -> %b, required -> %b", hist[i-1], hist[i], nxt); end
                nrun++;
                run = 1;
            end
        end
        n_checks++;
        if (nrun < 10) begin n_fail++; $display("FAIL scan_runs: got %0d transitions, required at least 10", nrun); end
    endtask

    task automatic test_positive();
        test_conversion("pos11", 6'b001011, -1, 6'd0);
        test_scan_order();
    endtask

    task automatic test_minimum();
        test_conversion("min", 6'b100000, -1, 6'd0);
    endtask

    task automatic test_zero_and_negative();
        test_conversion("zero", 6'b000000, -1, 6'd0);
        test_conversion("neg5", 6'b111011, -1, 6'd0);
    endtask

    task automatic test_load_during_conv();
        test_conversion("load_in_conv", 6'b011110, 2, 6'b000001);
    endtask

    task automatic test_load_at_completion();
        test_conversion("load_at_done", 6'b001111, 2, 6'b000011);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            test_conversion("rand", 6'($urandom_range(0, 63)), -1, 6'd0);
        end
    endtask

    task automatic test_reset_mid_conv();
        s = 6'd31;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || an !== 3'b111 || seg !== 7'h7F) begin
            n_fail++;
            $display("FAIL mid_conv_reset: busy=%b valid=%b an=%b seg=%h, required 0 0 111 7f", busy, valid, an, seg);
        end
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || an !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_conv_reset_hold: busy=%b valid=%b an=%b, required 0 0 111", busy, valid, an);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (valid !== 1'b0 || an !== 3'b111) begin
            n_fail++;
            $display("FAIL mid_conv_release: valid=%b an=%b, required 0 111", valid, an);
        end
        test_conversion("after_reset7", 6'd7, -1, 6'd0);
    endtask

    initial begin
        enc_tab[0] = 7'h3F; enc_tab[1] = 7'h06; enc_tab[2] = 7'h5B; enc_tab[3] = 7'h4F;
        enc_tab[4] = 7'h66; enc_tab[5] = 7'h6D; enc_tab[6] = 7'h7D; enc_tab[7] = 7'h07;
        enc_tab[8] = 7'h7F; enc_tab[9] = 7'h6F;
        rst_n = 1'b0;
        load  = 1'b0;
        s     = 6'd0;
        test_reset();
        test_positive();
        test_minimum();
        test_zero_and_negative();
        test_load_during_conv();
        test_load_at_completion();
        test_random();
        test_reset_mid_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/placar_display_c2.md
Name: placar_display_c2

Overview:
- Downstream stage of the 4-bit adder/subtractor.
- Captures the adder's 6-bit two's-complement result on a load strobe and converts it to sign plus two BCD digits by sequential repeated subtraction.
- Drives a 3-digit multiplexed 7-segment display: sign, tens, units.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays enabled; minimum 2.
SEG_ACTIVE_LOW, 1, 1 = seg and an active-low (common-anode board); 0 = both active-high.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
s  in  6  two's-complement result from the adder, range -32..31.
load  in  1  capture request; sampled only in IDLE.
busy  out  1  high while converting.
valid  out  1  high once the first conversion has completed; stays high until reset.
seg  out  7  segments {g,f,e,d,c,b,a}; polarity set by SEG_ACTIVE_LOW.
an  out  3  digit enables, one-hot: an[0] units, an[1] tens, an[2] sign.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0 and immediately after release:
  - state=IDLE, busy=0, valid=0.
  - Internal magnitude, tens, units and displayed registers all 0.
  - Prescaler=0, digit index=0.
  - seg=all off, an=all off.
- FSM states: IDLE, CONV.
- IDLE + load=1 at edge N:
  - Capture sign=s[5].
  - mag = sign ? (~s+1) : s, held in 6 bits unsigned, so -32 -> 32.
  - tens_w=0; next state CONV; busy=1 from edge N.
- CONV, once per cycle:
  - If mag>=10: mag-=10 and tens_w+=1.
  - Else: commit {sign, tens_w, mag} atomically to the displayed registers, set valid=1, busy=0, go to IDLE.
- Conversion takes floor(|s|/10)+1 cycles in CONV.
  - Example: |s|=25 -> 3 cycles; the displayed value updates at the 3rd edge after the load edge.
- load during CONV is ignored and not queued. s is sampled only at the load edge; later changes to s have no effect.
- The displayed value holds its previous content throughout CONV, so the display never shows partial results.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1 continuously from reset, independent of the FSM.
  - On wrap, digit index advances 0->1->2->0.
  - an and seg are both registered and change on the same edge.
- Digit content:
  - valid=0: an all off (blanked).
  - Units digit: always shows units, including 0.
  - Tens digit: shows tens when tens!=0; otherwise blank (leading-zero suppression; an still asserted, seg all off).
  - Sign digit: shows minus (g only) when sign=1; otherwise blank.
- Active-high encodings (inverted when SEG_ACTIVE_LOW=1):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - minus=40, blank=00.
- Range: tens is 0..3 and units 0..9 for all legal s. Every 6-bit pattern is legal.
- Reset mid-CONV: immediate return to the reset state; the partial result is discarded, valid=0, display blanked.
- Simultaneous load and CONV completion: load is ignored; the FSM is in IDLE only from the following cycle.

Test Plan:
- Reset, SEG_ACTIVE_LOW=1:
  - Required: busy=0, valid=0, an=111, seg=7F during reset and until the first completed conversion.
- Positive value, SCAN_DIV=4: s=001011 (+11), load pulse.
  - Required: busy high 2 cycles, then valid=1.
  - Scan shows units=06^7F=79, tens=79, sign=7F (blank).
  - an sequence 110,101,011, each held 4 cycles.
- Minimum value: s=100000 (-32).
  - Required: busy 4 cycles.
  - Display units=2 (24), tens=3 (30), sign=minus (3F).
- Zero, then a single-digit negative:
  - s=000000: display units=0 (40), tens blank (7F), sign blank; busy 1 cycle.
  - Then s=111011 (-5): units=5 (12), tens blank, sign=minus.
- Load during conversion: load s=011110 (+30); pulse load with s=000001 on the 2nd CONV cycle.
  - Required: the second load is ignored; final display is 30; busy deasserts after exactly 4 cycles.
- Reset mid-CONV: start a conversion of +31, assert rst_n=0 on the 2nd CONV cycle.
  - Required: outputs return immediately to reset values.
  - After release and load of +7: valid=1 after 1 cycle, display shows 7.
